// File: rtl/hwt_vector_sequencer.sv
// Vector sequencer and MISR response compactor for a 4-input combinational cell under test.
// It drives an incrementing vector on A..D, folds each registered Y into a 16-bit MISR, and compares the result with a golden signature.
module hwt_vector_sequencer #(
  parameter int unsigned NUM_VEC   = 16,
  parameter int unsigned CNT_W     = 5,
  parameter logic [15:0] MISR_POLY = 16'h1021,
  parameter logic [15:0] MISR_INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       seed,
  input  logic [15:0]      expected_sig,
  input  logic             y_in,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] ones_count,
  output logic             pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  state_t           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic             y_q, y_d;
  logic             cap_valid_q, cap_valid_d;
  logic [15:0]      sig_q, sig_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic bit_in);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {15'b0, bit_in};
  endfunction

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    vec_idx_d   = vec_idx_q;
    y_d         = y_q;
    cap_valid_d = cap_valid_q;
    sig_d       = sig_q;
    ones_d      = ones_q;

    // y_q lags the driven vector by one cycle, so folding is keyed on cap_valid rather than on state
    if (cap_valid_q) begin
      sig_d  = misr_step(sig_q, y_q);
      ones_d = ones_q + {{(CNT_W-1){1'b0}}, y_q};
    end

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d     = RUN;
          vec_d       = seed;
          vec_idx_d   = '0;
          cap_valid_d = 1'b0;
          sig_d       = MISR_INIT;
          ones_d      = '0;
        end
      end
      RUN: begin
        y_d         = y_in;
        cap_valid_d = 1'b1;
        vec_idx_d   = vec_idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (vec_idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          vec_d = vec_q + 4'd1;
        end
      end
      DRAIN: begin
        cap_valid_d = 1'b0;
        state_d     = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= 4'd0;
      vec_idx_q   <= '0;
      y_q         <= 1'b0;
      cap_valid_q <= 1'b0;
      sig_q       <= MISR_INIT;
      ones_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      vec_idx_q   <= vec_idx_d;
      y_q         <= y_d;
      cap_valid_q <= cap_valid_d;
      sig_q       <= sig_d;
      ones_q      <= ones_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign a_o        = vec_q[3];
  assign b_o        = vec_q[2];
  assign c_o        = vec_q[1];
  assign d_o        = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = sig_q;
  assign ones_count = ones_q;
  assign pass       = done_q && (sig_q == expected_sig);

endmodule

// File: tb/tb_hwt_vector_sequencer.sv
// Self-checking bench for hwt_vector_sequencer: the cell under test is modelled as a 16-entry truth table on A..D,
// and every run is checked against a behavioural model of the vector sequence and the MISR fold.
module tb_hwt_vector_sequencer;

   localparam int          NUM_VEC   = 16;
   localparam int          CNT_W     = 5;
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_INIT = 16'h0000;

   logic             clk;
   logic             rst;
   logic             start;
   logic [3:0]       seed;
   logic [15:0]      expectedSig;
   logic             yIn;
   logic             aO, bO, cO, dO;
   logic             busy, done, pass;
   logic [15:0]      signature;
   logic [CNT_W-1:0] onesCount;
   logic [15:0]      cellTable;

   int total = 0;
   int bad   = 0;

   hwt_vector_sequencer #(
      .NUM_VEC(NUM_VEC), .CNT_W(CNT_W), .MISR_POLY(MISR_POLY), .MISR_INIT(MISR_INIT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .expected_sig(expectedSig),
      .y_in(yIn), .a_o(aO), .b_o(bO), .c_o(cO), .d_o(dO), .busy(busy), .done(done),
      .signature(signature), .ones_count(onesCount), .pass(pass)
   );

   // The cell under test answers combinationally from whatever vector is on A..D
   assign yIn = cellTable[{aO, bO, cO, dO}];

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck run still ends with a report
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports each mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference: walk the vector sequence from the seed and fold each response into the MISR
   function automatic void modelRun(input logic [3:0] runSeed, input logic [15:0] tt,
                                    output logic [15:0] sig, output int ones);
      logic [3:0] v;
      logic       y;
      sig  = MISR_INIT;
      ones = 0;
      for (int i = 0; i < NUM_VEC; i++) begin
         v    = runSeed + 4'(i);
         y    = tt[v];
         sig  = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {15'b0, y};
         ones = ones + int'(y);
      end
   endfunction

   function automatic logic [15:0] trojanCellTable();
      logic [15:0] tt;
      logic [3:0]  v;
      for (int i = 0; i < 16; i++) begin
         v     = 4'(i);
         tt[i] = v[0] & ((v[3] & v[2]) | v[1]);
      end
      return tt;
   endfunction

   // One complete run; entered and left at #1 after a rising edge, and leaves the DUT in DONE
   task automatic applyStimulus(input logic [3:0] runSeed, input logic [15:0] tt, input logic [15:0] expSig,
                                input bit pulseMid, output logic [15:0] gotSig, output int gotOnes);
      logic [15:0] modelSig;
      int          modelOnes;
      logic [3:0]  expVec;
      modelRun(runSeed, tt, modelSig, modelOnes);
      cellTable   = tt;
      expectedSig = expSig;
      seed        = runSeed;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seed  = 4'($urandom);
      checkOutput("doneDrop", 32'(done), 32'd0);
      for (int i = 0; i < NUM_VEC; i++) begin
         expVec = runSeed + 4'(i);
         checkOutput("vector", 32'({aO, bO, cO, dO}), 32'(expVec));
         checkOutput("busyRun", 32'(busy), 32'd1);
         start = (pulseMid && (i == 3 || i == 8)) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
      end
      start  = 1'b0;
      expVec = runSeed + 4'(NUM_VEC - 1);
      checkOutput("busyDrain", 32'(busy), 32'd1);
      checkOutput("doneDrain", 32'(done), 32'd0);
      checkOutput("vecHold", 32'({aO, bO, cO, dO}), 32'(expVec));
      @(posedge clk); #1;
      checkOutput("doneSet", 32'(done), 32'd1);
      checkOutput("busyClear", 32'(busy), 32'd0);
      checkOutput("signature", 32'(signature), 32'(modelSig));
      checkOutput("onesCount", 32'(onesCount), 32'(modelOnes));
      checkOutput("pass", 32'(pass), 32'(modelSig == expSig));
      gotSig  = signature;
      gotOnes = int'(onesCount);
   endtask

   initial begin
      logic [15:0] sigA, sigB, ttTrojan, ttRand, modelSig;
      int          onesA, onesB, modelOnes;
      logic [3:0]  rSeed;

      rst         = 1'b1;
      start       = 1'b0;
      seed        = 4'd0;
      expectedSig = 16'h0000;
      cellTable   = 16'h0000;
      ttTrojan    = trojanCellTable();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstVec", 32'({aO, bO, cO, dO}), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstSig", 32'(signature), 32'(MISR_INIT));
      checkOutput("rstOnes", 32'(onesCount), 32'd0);
      checkOutput("rstPass", 32'(pass), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] reset in the middle of a run");
      cellTable = 16'hFFFF;
      seed      = 4'd3;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midRstVec", 32'({aO, bO, cO, dO}), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstDone", 32'(done), 32'd0);
      checkOutput("midRstSig", 32'(signature), 32'(MISR_INIT));
      checkOutput("midRstOnes", 32'(onesCount), 32'd0);
      checkOutput("midRstPass", 32'(pass), 32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] all-zero response");
      applyStimulus(4'd0, 16'h0000, 16'h0000, 1'b0, sigA, onesA);
      checkOutput("zeroSig", 32'(sigA), 32'h0000);
      checkOutput("zeroPass", 32'(pass), 32'd1);
      @(posedge clk); #1;
      checkOutput("doneHold", 32'(done), 32'd1);
      checkOutput("sigFrozen", 32'(signature), 32'h0000);

      $display("[TB] single one on vector 0");
      applyStimulus(4'd0, 16'h0001, 16'h8000, 1'b0, sigA, onesA);
      checkOutput("vec0Sig", 32'(sigA), 32'h8000);
      checkOutput("vec0Ones", 32'(onesA), 32'd1);

      $display("[TB] trojan cell function, seed 0 and seed A");
      applyStimulus(4'd0, ttTrojan, 16'h0000, 1'b0, sigA, onesA);
      checkOutput("trojanOnes0", 32'(onesA), 32'd5);
      applyStimulus(4'hA, ttTrojan, sigA, 1'b0, sigB, onesB);
      checkOutput("trojanOnesA", 32'(onesB), 32'd5);
      checkOutput("trojanSigDiffers", 32'(sigA != sigB), 32'd1);
      checkOutput("trojanPassMiss", 32'(pass), 32'd0);

      $display("[TB] start pulses while busy, then back-to-back identical runs");
      applyStimulus(4'd0, ttTrojan, sigA, 1'b1, sigB, onesB);
      checkOutput("ignoreStartSig", 32'(sigB), 32'(sigA));
      checkOutput("ignoreStartPass", 32'(pass), 32'd1);
      applyStimulus(4'd0, ttTrojan, sigA, 1'b0, sigB, onesB);
      checkOutput("backToBackSig", 32'(sigB), 32'(sigA));

      $display("[TB] randomized runs");
      for (int r = 0; r < 8; r++) begin
         rSeed  = 4'($urandom);
         ttRand = 16'($urandom);
         modelRun(rSeed, ttRand, modelSig, modelOnes);
         applyStimulus(rSeed, ttRand, (r % 2 == 0) ? modelSig : (modelSig ^ 16'($urandom_range(1, 65535))),
                       1'($urandom_range(0, 1)), sigA, onesA);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hwt_vector_sequencer.md
Name: hwt_vector_sequencer

Overview:
- Upstream stimulus generator and downstream response compactor for the 4-input trojan-candidate combinational cell (inputs A/B/C/D, output Y).
- Drives a deterministic vector sequence onto A..D and samples Y through one capture register.
- Folds each response into a 16-bit MISR signature and counts ones, then compares the signature with a golden value.
- Used for golden-vs-suspect signature comparison in the trojan-detection flow.

Parameters:
NUM_VEC, 16, number of vectors per run (1..2^CNT_W-1)
CNT_W, 5, width of vector counter and ones_count
MISR_POLY, 16'h1021, MISR feedback taps
MISR_INIT, 16'h0000, MISR value at start of each run

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin run; sampled only in IDLE or DONE
seed  input  4  first vector value, captured on accepted start
expected_sig  input  16  golden signature, compared combinationally in DONE
y_in  input  1  Y returned from the cell under test
a_o  output  1  stimulus A = vec[3]
b_o  output  1  stimulus B = vec[2]
c_o  output  1  stimulus C = vec[1]
d_o  output  1  stimulus D = vec[0]
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE; held until next accepted start
signature  output  16  MISR contents
ones_count  output  CNT_W  number of captured y==1 responses
pass  output  1  done && (signature == expected_sig)

Behaviour:
- Reset (async, active-high): state=IDLE; vec=0 (a_o..d_o=0); vec_idx=0; y_q=0; cap_valid=0; signature=MISR_INIT; ones_count=0; busy=0; done=0; pass=0.
- IDLE:
  - start=1 -> RUN.
  - On that edge: vec<=seed, vec_idx<=0, signature<=MISR_INIT, ones_count<=0, cap_valid<=0.
- RUN: vector vec is driven for exactly one cycle. Each edge:
  - y_q<=y_in; cap_valid<=1.
  - vec<=vec+1 (mod 16, wraps 4'hF->4'h0).
  - vec_idx<=vec_idx+1.
  - When vec_idx==NUM_VEC-1: go to DRAIN; vec holds its last value.
- Capture pipeline:
  - y_q holds the response to the vector driven in the previous cycle.
  - On every edge where cap_valid=1 (RUN or DRAIN), fold y_q:
    - signature <= {signature[14:0],1'b0} ^ (signature[15] ? MISR_POLY : 0) ^ {15'b0,y_q}
    - ones_count <= ones_count + y_q
- DRAIN: one cycle. Fold the final y_q, then cap_valid<=0 and go to DONE. Exactly NUM_VEC folds occur per run.
- DONE:
  - done=1; signature and ones_count frozen; pass is valid.
  - start=1 restarts as from IDLE (same edge actions); done drops on the next cycle.
- start while busy: ignored, no effect on the run.
- seed changes after acceptance: no effect until the next run.
- Latency: start edge -> DONE after NUM_VEC+1 further edges. busy is high for NUM_VEC+1 cycles.
- Reset mid-run: immediate return to reset values; partial signature discarded.
- ones_count never overflows, since NUM_VEC < 2^CNT_W.

Test Plan:
- Reset during RUN (after 5 vectors) -> all outputs immediately at reset values; next start gives a full fresh run.
- seed=0, y_in tied 0, NUM_VEC=16 -> vectors 0..15 one per cycle; done 17 cycles after start; signature=16'h0000, ones_count=0; pass=1 with expected_sig=0.
- seed=0, y_in=1 only while vector 0 is driven -> signature=16'h8000 (1 shifted 15 times, no feedback); ones_count=1.
- Exhaustive run: y_in = d_o & ((a_o&b_o)|c_o) model, seed=0 -> ones_count=5.
  - Re-run with seed=4'hA (wraps F->0) -> ones_count=5 again, signature differs.
  - expected_sig mismatch -> pass=0, done=1.
- start pulsed at RUN cycles 3 and 8 -> ignored; run length and signature are identical to a clean run.
- Back-to-back runs: start asserted in the same cycle done=1 -> MISR reinitialised; the second run's signature equals the first for identical stimulus.
